fb_write_arbiter: RTL and testbench

Shares the frame-buffer (6-bitplane RAM) write port and the palette-RAM write port between two external requesters and an internal rectangular-free linear fill engine. Sits between the UART loader / future blitter and the video RAMs inside the video generator, so that the RAMs keep a single write port while several sources write into them. At most one write is issued per clock, and every write is acknowledged.

---
 rtl/fb_arb_pkg.sv | 58 +++++
 rtl/fb_fill_engine.sv | 97 +++++++++
 rtl/fb_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame-buffer / palette write arbiter.
package fb_arb_pkg;

    localparam int FB_ADDR_W  = 16;
    localparam int FB_DATA_W  = 8;
    localparam int PAL_ADDR_W = 6;
    localparam int PAL_DATA_W = 12;

    localparam logic SEL_FB  = 1'b0;
    localparam logic SEL_PAL = 1'b1;

    typedef enum logic [1:0] {
        REQ_A    = 2'd0,
        REQ_B    = 2'd1,
        REQ_FILL = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

    // Rotating-priority pick: search starts at the id after 'last'.
    // elig/return bit 0 = A, bit 1 = B, bit 2 = FILL; result is one-hot or zero.
    function automatic logic [2:0] rr_pick(input req_id_e last, input logic [2:0] elig);
        logic [2:0] g;
        g = 3'b000;
        case (last)
            REQ_A: begin
                if (elig[1])      g = 3'b010;
                else if (elig[2]) g = 3'b100;
                else if (elig[0]) g = 3'b001;
                else              g = 3'b000;
            end
            REQ_B: begin
                if (elig[2])      g = 3'b100;
                else if (elig[0]) g = 3'b001;
                else if (elig[1]) g = 3'b010;
                else              g = 3'b000;
            end
            REQ_FILL: begin
                if (elig[0])      g = 3'b001;
                else if (elig[1]) g = 3'b010;
                else if (elig[2]) g = 3'b100;
                else              g = 3'b000;
            end
            default: begin
                if (elig[0])      g = 3'b001;
                else if (elig[1]) g = 3'b010;
                else if (elig[2]) g = 3'b100;
                else              g = 3'b000;
            end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fb_fill_engine.sv
// Linear fill engine: writes a constant byte to a run of consecutive
// frame-buffer addresses, one byte per granted cycle, wrapping at 2^ADDR_W.
module fb_fill_engine
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_len,
    input  logic [DATA_W-1:0] i_value,
    input  logic              i_grant,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_value,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    fill_state_e       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cur, w_cur_nxt;
    logic [ADDR_W-1:0] r_rem, w_rem_nxt;
    logic [DATA_W-1:0] r_val, w_val_nxt;
    logic              r_busy;
    logic              r_done;

    // Next-state and counter update; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_rem_nxt   = r_rem;
        w_val_nxt   = r_val;
        case (r_state)
            FILL_IDLE: begin
                if (i_start) begin
                    w_cur_nxt = i_base;
                    w_rem_nxt = i_len;
                    w_val_nxt = i_value;
                    if (i_len == ZERO) begin
                        w_state_nxt = FILL_DONE;
                    end else begin
                        w_state_nxt = FILL_RUN;
                    end
                end else begin
                    w_state_nxt = FILL_IDLE;
                end
            end
            FILL_RUN: begin
                if (i_grant) begin
                    w_cur_nxt = r_cur + ONE;
                    w_rem_nxt = r_rem - ONE;
                    if (r_rem == ONE) begin
                        w_state_nxt = FILL_DONE;
                    end else begin
                        w_state_nxt = FILL_RUN;
                    end
                end else begin
                    w_state_nxt = FILL_RUN;
                end
            end
            FILL_DONE: w_state_nxt = FILL_IDLE;
            default:   w_state_nxt = FILL_IDLE;
        endcase
    end

    // State, counters and registered busy/done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL_IDLE;
            r_cur   <= ZERO;
            r_rem   <= ZERO;
            r_val   <= {DATA_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_rem   <= w_rem_nxt;
            r_val   <= w_val_nxt;
            r_busy  <= (w_state_nxt == FILL_RUN);
            r_done  <= (w_state_nxt == FILL_DONE);
        end
    end

    assign o_req   = r_busy & (r_rem != ZERO);
    assign o_addr  = r_cur;
    assign o_value = r_val;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates the single frame-buffer and palette write ports between two
// external requesters and the internal fill engine, one write per clock.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W  = FB_ADDR_W,
    parameter int DATA_W  = FB_DATA_W,
    parameter int PADDR_W = PAL_ADDR_W,
    parameter int PDATA_W = PAL_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_sel,
    input  logic [ADDR_W-1:0]  a_addr,
    input  logic [PDATA_W-1:0] a_data,
    output logic               a_ack,
    input  logic               b_req,
    input  logic               b_sel,
    input  logic [ADDR_W-1:0]  b_addr,
    input  logic [PDATA_W-1:0] b_data,
    output logic               b_ack,
    input  logic               fill_start,
    input  logic [ADDR_W-1:0]  fill_base,
    input  logic [ADDR_W-1:0]  fill_len,
    input  logic [DATA_W-1:0]  fill_value,
    output logic               fill_busy,
    output logic               fill_done,
    output logic               ram_writeenable,
    output logic [ADDR_W-1:0]  ram_waddr,
    output logic [DATA_W-1:0]  ram_write,
    output logic               pram_writeenable,
    output logic [PADDR_W-1:0] pram_waddr,
    output logic [PDATA_W-1:0] pram_write
);

    logic               w_fill_req;
    logic [ADDR_W-1:0]  w_fill_addr;
    logic [DATA_W-1:0]  w_fill_value;
    logic [2:0]         w_elig;
    logic [2:0]         w_grant;
    req_id_e            w_grant_id;

    logic               w_ram_we_nxt;
    logic [ADDR_W-1:0]  w_ram_waddr_nxt;
    logic [DATA_W-1:0]  w_ram_wdata_nxt;
    logic               w_pram_we_nxt;
    logic [PADDR_W-1:0] w_pram_waddr_nxt;
    logic [PDATA_W-1:0] w_pram_wdata_nxt;

    req_id_e            r_last_grant;
    logic               r_a_ack;
    logic               r_b_ack;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_waddr;
    logic [DATA_W-1:0]  r_ram_wdata;
    logic               r_pram_we;
    logic [PADDR_W-1:0] r_pram_waddr;
    logic [PDATA_W-1:0] r_pram_wdata;

    fb_fill_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .clk     (clk),
        .rst     (rst),
        .i_start (fill_start),
        .i_base  (fill_base),
        .i_len   (fill_len),
        .i_value (fill_value),
        .i_grant (w_grant[2]),
        .o_req   (w_fill_req),
        .o_addr  (w_fill_addr),
        .o_value (w_fill_value),
        .o_busy  (fill_busy),
        .o_done  (fill_done)
    );

    // A requester in its ack cycle is masked so a held req is not issued twice.
    assign w_elig = {w_fill_req, b_req & ~r_b_ack, a_req & ~r_a_ack};
    assign w_grant = rr_pick(r_last_grant, w_elig);

    // Encode the one-hot grant; no grant keeps the pointer where it is.
    always_comb begin
        w_grant_id = r_last_grant;
        case (w_grant)
            3'b001:  w_grant_id = REQ_A;
            3'b010:  w_grant_id = REQ_B;
            3'b100:  w_grant_id = REQ_FILL;
            default: w_grant_id = r_last_grant;
        endcase
    end

    // Route the granted source to one write port; idle ports hold addr/data.
    always_comb begin
        w_ram_we_nxt     = 1'b0;
        w_ram_waddr_nxt  = r_ram_waddr;
        w_ram_wdata_nxt  = r_ram_wdata;
        w_pram_we_nxt    = 1'b0;
        w_pram_waddr_nxt = r_pram_waddr;
        w_pram_wdata_nxt = r_pram_wdata;
        if (w_grant[0]) begin
            if (a_sel == SEL_PAL) begin
                w_pram_we_nxt    = 1'b1;
                w_pram_waddr_nxt = a_addr[PADDR_W-1:0];
                w_pram_wdata_nxt = a_data;
            end else begin
                w_ram_we_nxt    = 1'b1;
                w_ram_waddr_nxt = a_addr;
                w_ram_wdata_nxt = a_data[DATA_W-1:0];
            end
        end else if (w_grant[1]) begin
            if (b_sel == SEL_PAL) begin
                w_pram_we_nxt    = 1'b1;
                w_pram_waddr_nxt = b_addr[PADDR_W-1:0];
                w_pram_wdata_nxt = b_data;
            end else begin
                w_ram_we_nxt    = 1'b1;
                w_ram_waddr_nxt = b_addr;
                w_ram_wdata_nxt = b_data[DATA_W-1:0];
            end
        end else if (w_grant[2]) begin
            w_ram_we_nxt    = 1'b1;
            w_ram_waddr_nxt = w_fill_addr;
            w_ram_wdata_nxt = w_fill_value;
        end else begin
            w_ram_we_nxt  = 1'b0;
            w_pram_we_nxt = 1'b0;
        end
    end

    // Register strobes, acks, write buses and the rotating-priority pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= REQ_FILL;
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_waddr  <= {ADDR_W{1'b0}};
            r_ram_wdata  <= {DATA_W{1'b0}};
            r_pram_we    <= 1'b0;
            r_pram_waddr <= {PADDR_W{1'b0}};
            r_pram_wdata <= {PDATA_W{1'b0}};
        end else begin
            r_last_grant <= w_grant_id;
            r_a_ack      <= w_grant[0];
            r_b_ack      <= w_grant[1];
            r_ram_we     <= w_ram_we_nxt;
            r_ram_waddr  <= w_ram_waddr_nxt;
            r_ram_wdata  <= w_ram_wdata_nxt;
            r_pram_we    <= w_pram_we_nxt;
            r_pram_waddr <= w_pram_waddr_nxt;
            r_pram_wdata <= w_pram_wdata_nxt;
        end
    end

    assign a_ack            = r_a_ack;
    assign b_ack            = r_b_ack;
    assign ram_writeenable  = r_ram_we;
    assign ram_waddr        = r_ram_waddr;
    assign ram_write        = r_ram_wdata;
    assign pram_writeenable = r_pram_we;
    assign pram_waddr       = r_pram_waddr;
    assign pram_write       = r_pram_wdata;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed cases with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_fb_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req, a_sel, a_ack;
    logic [15:0] a_addr;
    logic [11:0] a_data;
    logic        b_req, b_sel, b_ack;
    logic [15:0] b_addr;
    logic [11:0] b_data;
    logic        fill_start, fill_busy, fill_done;
    logic [15:0] fill_base, fill_len;
    logic [7:0]  fill_value;
    logic        ram_writeenable, pram_writeenable;
    logic [15:0] ram_waddr;
    logic [7:0]  ram_write;
    logic [5:0]  pram_waddr;
    logic [11:0] pram_write;

    fb_write_arbiter #(
        .ADDR_W (16),
        .DATA_W (8),
        .PADDR_W(6),
        .PDATA_W(12)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .a_req            (a_req),
        .a_sel            (a_sel),
        .a_addr           (a_addr),
        .a_data           (a_data),
        .a_ack            (a_ack),
        .b_req            (b_req),
        .b_sel            (b_sel),
        .b_addr           (b_addr),
        .b_data           (b_data),
        .b_ack            (b_ack),
        .fill_start       (fill_start),
        .fill_base        (fill_base),
        .fill_len         (fill_len),
        .fill_value       (fill_value),
        .fill_busy        (fill_busy),
        .fill_done        (fill_done),
        .ram_writeenable  (ram_writeenable),
        .ram_waddr        (ram_waddr),
        .ram_write        (ram_write),
        .pram_writeenable (pram_writeenable),
        .pram_waddr       (pram_waddr),
        .pram_write       (pram_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        e_a_ack, e_b_ack, e_ram_we, e_pram_we, e_busy, e_done;
    logic [15:0] e_ram_waddr;
    logic [7:0]  e_ram_write;
    logic [5:0]  e_pram_waddr;
    logic [11:0] e_pram_write;
    int          m_last;   // 0 = A, 1 = B, 2 = FILL
    int          m_rem;
    int          m_cur;
    int          m_val;

    task automatic model_reset();
        e_a_ack = 1'b0; e_b_ack = 1'b0; e_ram_we = 1'b0; e_pram_we = 1'b0;
        e_busy = 1'b0; e_done = 1'b0;
        e_ram_waddr = 16'h0; e_ram_write = 8'h0; e_pram_waddr = 6'h0; e_pram_write = 12'h0;
        m_last = 2; m_rem = 0; m_cur = 0; m_val = 0;
    endtask

    task automatic model_step();
        bit          el[3];
        int          win;
        bit          old_busy, old_done, sel;
        logic [15:0] addr;
        logic [11:0] data;
        el[0] = a_req && !e_a_ack;
        el[1] = b_req && !e_b_ack;
        el[2] = e_busy && (m_rem > 0);
        win = -1;
        for (int k = 1; k <= 3; k++) begin
            int id;
            id = (m_last + k) % 3;
            if (win < 0 && el[id]) win = id;
        end
        e_a_ack = (win == 0);
        e_b_ack = (win == 1);
        e_ram_we = 1'b0;
        e_pram_we = 1'b0;
        if (win == 0 || win == 1) begin
            sel  = (win == 0) ? a_sel  : b_sel;
            addr = (win == 0) ? a_addr : b_addr;
            data = (win == 0) ? a_data : b_data;
            if (sel) begin
                e_pram_we = 1'b1; e_pram_waddr = addr[5:0]; e_pram_write = data;
            end else begin
                e_ram_we = 1'b1; e_ram_waddr = addr; e_ram_write = data[7:0];
            end
        end else if (win == 2) begin
            e_ram_we = 1'b1;
            e_ram_waddr = m_cur[15:0];
            e_ram_write = m_val[7:0];
            m_cur = (m_cur + 1) % 65536;
            m_rem = m_rem - 1;
        end
        old_busy = e_busy;
        old_done = e_done;
        if (old_busy) begin
            if (m_rem == 0) begin e_busy = 1'b0; e_done = 1'b1; end
        end else if (old_done) begin
            e_done = 1'b0;
        end else if (fill_start) begin
            if (fill_len == 16'd0) e_done = 1'b1;
            else begin
                e_busy = 1'b1; m_rem = int'(fill_len); m_cur = int'(fill_base); m_val = int'(fill_value);
            end
        end
        if (win >= 0) m_last = win;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Compare every output with the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("a_ack", a_ack, e_a_ack);
            check("b_ack", b_ack, e_b_ack);
            check("fill_busy", fill_busy, e_busy);
            check("fill_done", fill_done, e_done);
            check("ram_we", ram_writeenable, e_ram_we);
            check("ram_waddr", ram_waddr, e_ram_waddr);
            check("ram_write", ram_write, e_ram_write);
            check("pram_we", pram_writeenable, e_pram_we);
            check("pram_waddr", pram_waddr, e_pram_waddr);
            check("pram_write", pram_write, e_pram_write);
            check("one_strobe", ram_writeenable & pram_writeenable, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] wrap_addr[4];
    int nw, nd, gid;
    bit a_pend, b_pend;

    initial begin
        wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF;
        wrap_addr[2] = 16'h0000; wrap_addr[3] = 16'h0001;
        rst = 1'b0;
        a_req = 1'b0; a_sel = 1'b0; a_addr = 16'h0; a_data = 12'h0;
        b_req = 1'b0; b_sel = 1'b0; b_addr = 16'h0; b_data = 12'h0;
        fill_start = 1'b0; fill_base = 16'h0; fill_len = 16'h0; fill_value = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we", ram_writeenable, 1'b0);
        check("rst_busy", fill_busy, 1'b0);
        check("rst_waddr", ram_waddr, 16'h0000);
        rst = 1'b1;
        tick(); tick();

        // Single frame-buffer write from A, req held across ack.
        a_sel = 1'b0; a_addr = 16'h1234; a_data = 12'h05A; a_req = 1'b1;
        tick();
        check("t1_we", ram_writeenable, 1'b1);
        check("t1_addr", ram_waddr, 16'h1234);
        check("t1_data", ram_write, 8'h5A);
        check("t1_ack", a_ack, 1'b1);
        tick();
        check("t1_ack_gap", a_ack, 1'b0);
        check("t1_we_gap", ram_writeenable, 1'b0);
        tick();
        check("t1_ack2", a_ack, 1'b1);
        a_req = 1'b0;
        tick();
        check("t1_ack_off", a_ack, 1'b0);

        // Palette write from B.
        b_sel = 1'b1; b_addr = 16'h0003; b_data = 12'hF80; b_req = 1'b1;
        tick();
        check("t2_pwe", pram_writeenable, 1'b1);
        check("t2_paddr", pram_waddr, 6'd3);
        check("t2_pdata", pram_write, 12'hF80);
        check("t2_we", ram_writeenable, 1'b0);
        check("t2_ack", b_ack, 1'b1);
        b_req = 1'b0;
        tick();

        // Fill wrapping across the top of the address space.
        fill_base = 16'hFFFE; fill_len = 16'd4; fill_value = 8'h00; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("t3_busy", fill_busy, 1'b1);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_we", ram_writeenable, 1'b1);
            check("t3_addr", ram_waddr, wrap_addr[i]);
            check("t3_data", ram_write, 8'h00);
            nd += int'(fill_done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            nd += int'(fill_done);
        end
        check("t3_done_cnt", nd, 1);
        check("t3_busy_end", fill_busy, 1'b0);

        // Zero-length fill.
        fill_len = 16'd0; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("t4_done", fill_done, 1'b1);
        check("t4_we", ram_writeenable, 1'b0);
        check("t4_busy", fill_busy, 1'b0);
        tick();
        check("t4_done_off", fill_done, 1'b0);

        // 100-byte fill with an ignored second start.
        fill_base = 16'h0100; fill_len = 16'd100; fill_value = 8'hA5; fill_start = 1'b1;
        tick();
        nw = 0; nd = 0;
        for (int i = 0; i < 115; i++) begin
            if (i == 20) begin
                fill_base = 16'h8000; fill_len = 16'd5; fill_start = 1'b1;
            end else begin
                fill_start = 1'b0;
            end
            tick();
            nw += int'(ram_writeenable);
            nd += int'(fill_done);
        end
        check("t5_writes", nw, 100);
        check("t5_done_cnt", nd, 1);

        // Rotation A,B,FILL right after reset.
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        fill_base = 16'h2000; fill_len = 16'd30; fill_value = 8'h3C; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        a_req = 1'b1; a_sel = 1'b0; a_addr = 16'h0010; a_data = 12'h011;
        b_req = 1'b1; b_sel = 1'b1; b_addr = 16'h0020; b_data = 12'h022;
        for (int i = 0; i < 9; i++) begin
            tick();
            gid = a_ack ? 0 : (b_ack ? 1 : (ram_writeenable ? 2 : 3));
            check("t6_grant", gid, i % 3);
        end
        a_req = 1'b0; b_req = 1'b0;
        for (int i = 0; i < 60 && fill_busy; i++) tick();
        check("t6_drain", fill_busy, 1'b0);
        tick();

        // Reset in the middle of a fill with 50 bytes left.
        fill_base = 16'h4000; fill_len = 16'd100; fill_value = 8'h77; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (50) tick();
        check("t7_last_addr", ram_waddr, 16'h4031);
        #1;
        rst = 1'b0;
        #1;
        check("t7_we", ram_writeenable, 1'b0);
        check("t7_addr", ram_waddr, 16'h0000);
        check("t7_data", ram_write, 8'h00);
        check("t7_busy", fill_busy, 1'b0);
        check("t7_done", fill_done, 1'b0);
        nw = 0; nd = 0;
        repeat (3) begin
            tick();
            nw += int'(ram_writeenable);
            nd += int'(fill_done);
        end
        rst = 1'b1;
        repeat (5) begin
            tick();
            nw += int'(ram_writeenable);
            nd += int'(fill_done);
        end
        check("t7_no_writes", nw, 0);
        check("t7_no_done", nd, 0);
        fill_base = 16'h0040; fill_len = 16'd3; fill_value = 8'h11; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        nw = 0; nd = 0;
        repeat (6) begin
            tick();
            nw += int'(ram_writeenable);
            nd += int'(fill_done);
        end
        check("t7_fresh_writes", nw, 3);
        check("t7_fresh_done", nd, 1);

        // Randomized traffic against the model.
        a_pend = 1'b0; b_pend = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) rst = 1'b0;
            if (cyc == 1502) rst = 1'b1;

            if (e_a_ack) a_pend = 1'b0;
            if (a_pend && $urandom_range(0, 15) == 0) begin
                a_pend = 1'b0; a_req = 1'b0;
            end else if (!a_pend) begin
                a_sel = 1'($urandom_range(0, 1));
                a_addr = 16'($urandom);
                a_data = 12'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    a_pend = 1'b1; a_req = 1'b1;
                end else begin
                    a_req = 1'b0;
                end
            end

            if (e_b_ack) b_pend = 1'b0;
            if (b_pend && $urandom_range(0, 15) == 0) begin
                b_pend = 1'b0; b_req = 1'b0;
            end else if (!b_pend) begin
                b_sel = 1'($urandom_range(0, 1));
                b_addr = 16'($urandom);
                b_data = 12'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    b_pend = 1'b1; b_req = 1'b1;
                end else begin
                    b_req = 1'b0;
                end
            end

            if (fill_start) begin
                fill_start = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                fill_start = 1'b1;
                if ($urandom_range(0, 3) == 0) fill_base = 16'hFFF8 + 16'($urandom_range(0, 7));
                else fill_base = 16'($urandom);
                fill_len = 16'($urandom_range(0, 12));
                fill_value = 8'($urandom);
            end
            tick();
        end

        a_req = 1'b0; b_req = 1'b0; fill_start = 1'b0;
        repeat (20) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
